// File: rtl/intc.sv
// Bus-mapped interrupt controller: edge-latched pending bits, enable mask,
// fixed-priority (lowest index first) single request with req/ack/EOI handshake.
// Bus reads are combinational; irq_req rises one cycle after PEND&ENA goes nonzero.
module intc #(
    parameter int WIDTH = 32,
    parameter int NIRQ  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic             wen,
    input  logic [2:0]       addr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    input  logic [NIRQ-1:0]  irq_in,
    output logic             irq_req,
    output logic [4:0]       irq_vec,
    input  logic             irq_ack,
    input  logic             irq_eoi
);

    typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;

    state_t          state;
    logic [NIRQ-1:0] pend;
    logic [NIRQ-1:0] ena;
    logic [NIRQ-1:0] prev;
    logic            primed;

    logic [NIRQ-1:0] rise;
    logic [NIRQ-1:0] w1c;
    logic [NIRQ-1:0] swset;
    logic [NIRQ-1:0] live;
    logic [NIRQ-1:0] pend_nxt;
    logic [4:0]      cand;
    logic            any;
    logic            wr;
    logic            ack_fire;
    logic            eoi_fire;
    logic            cur_live;
    logic [WIDTH-1:0] stat;

    // Decode bus writes, edges and handshake events.
    // primed masks the first post-reset cycle so a line held high through
    // reset is not mistaken for a rising edge.
    always_comb begin
        wr       = cs & wen;
        rise     = primed ? (irq_in & ~prev) : '0;
        w1c      = (wr && addr == 3'd0) ? din[NIRQ-1:0] : '0;
        swset    = (wr && addr == 3'd5) ? din[NIRQ-1:0] : '0;
        live     = pend & ena;
        any      = |live;
        cur_live = live[irq_vec];
        ack_fire = (state == REQ) && irq_ack;
        eoi_fire = (state == SVC) && (irq_eoi || (wr && addr == 3'd3));
    end

    // Fixed priority: lowest enabled pending index wins.
    always_comb begin
        cand = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (live[i]) cand = 5'(i);
        end
    end

    // PEND next state: clears first, then sets, so a same-cycle edge is never lost.
    always_comb begin
        pend_nxt = pend & ~w1c;
        if (ack_fire) pend_nxt[irq_vec] = 1'b0;
        pend_nxt = pend_nxt | rise | swset;
    end

    // Pending, enable and edge-detect registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend   <= '0;
            ena    <= '0;
            prev   <= '0;
            primed <= 1'b0;
        end else begin
            pend   <= pend_nxt;
            prev   <= irq_in;
            primed <= 1'b1;
            if (wr && addr == 3'd1) ena <= din[NIRQ-1:0];
        end
    end

    // Request FSM with registered irq_req/irq_vec; the vector is frozen
    // from request through service so late higher-priority arrivals wait.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            irq_req <= 1'b0;
            irq_vec <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        state   <= REQ;
                        irq_req <= 1'b1;
                        irq_vec <= cand;
                    end
                end
                REQ: begin
                    if (ack_fire) begin
                        state   <= SVC;
                        irq_req <= 1'b0;
                    end else if (!cur_live) begin
                        state   <= IDLE;
                        irq_req <= 1'b0;
                    end
                end
                SVC: begin
                    irq_req <= 1'b0;
                    if (eoi_fire) state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    irq_req <= 1'b0;
                end
            endcase
        end
    end

    // Status word and combinational read mux; idle bus drives zero.
    always_comb begin
        stat       = '0;
        stat[0]    = irq_req;
        stat[1]    = (state == SVC);
        stat[12:8] = irq_vec;
        dout       = '0;
        if (cs && !wen) begin
            case (addr)
                3'd0:    dout = WIDTH'(pend);
                3'd1:    dout = WIDTH'(ena);
                3'd2:    dout = stat;
                3'd4:    dout = WIDTH'(irq_in);
                default: dout = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_intc.sv
// Directed bench for intc: reset, basic flow, priority, withdrawal,
// simultaneous set/clear, and reset during service.
module tb_intc;

    logic        clk;
    logic        reset;
    logic        cs;
    logic        wen;
    logic [2:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic [31:0] irq_in;
    logic        irq_req;
    logic [4:0]  irq_vec;
    logic        irq_ack;
    logic        irq_eoi;

    int checks;
    int failures;
    logic [31:0] rd;

    intc #(.WIDTH(32), .NIRQ(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .cs      (cs),
        .wen     (wen),
        .addr    (addr),
        .din     (din),
        .dout    (dout),
        .irq_in  (irq_in),
        .irq_req (irq_req),
        .irq_vec (irq_vec),
        .irq_ack (irq_ack),
        .irq_eoi (irq_eoi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        cs = 1'b1; wen = 1'b1; addr = a; din = d;
        tick();
        cs = 1'b0; wen = 1'b0; addr = '0; din = '0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        cs = 1'b1; wen = 1'b0; addr = a;
        #1;
        d = dout;
        cs = 1'b0; addr = '0;
        #1;
    endtask

    task automatic chk_reg(input string tag, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] v;
        bus_read(a, v);
        chk(tag, v, exp);
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic pulse(input logic [31:0] lines);
        irq_in = lines;
        tick();
        irq_in = '0;
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1; cs = 1'b0; wen = 1'b0; addr = '0; din = '0;
        irq_in = 32'h1; irq_ack = 1'b0; irq_eoi = 1'b0;

        // Reset with line 0 held high throughout and afterwards.
        repeat (3) tick();
        reset = 1'b0;
        repeat (3) tick();
        chk_reg("rst_pend", 3'd0, 32'h0);
        chk_reg("rst_ena",  3'd1, 32'h0);
        chk_reg("rst_stat", 3'd2, 32'h0);
        chk_reg("rst_raw",  3'd4, 32'h1);
        chk("rst_req", {31'b0, irq_req}, 32'h0);
        chk_reg("rst_reg7", 3'd7, 32'h0);
        irq_in = '0;
        tick();

        // Idle bus output is zero even when cs selects a register during a write.
        cs = 1'b1; wen = 1'b1; addr = 3'd4; din = 32'h0; #1;
        chk("dout_on_write", dout, 32'h0);
        cs = 1'b0; wen = 1'b0; #1;

        // Basic flow.
        bus_write(3'd1, 32'h1);
        pulse(32'h1);
        chk_reg("basic_pend", 3'd0, 32'h1);
        chk("basic_req_not_yet", {31'b0, irq_req}, 32'h0);
        tick();
        chk("basic_req", {31'b0, irq_req}, 32'h1);
        chk("basic_vec", {27'b0, irq_vec}, 32'h0);
        ack();
        chk_reg("basic_pend_ack", 3'd0, 32'h0);
        chk_reg("basic_stat_svc", 3'd2, 32'h002);
        bus_write(3'd3, 32'h0);
        chk_reg("basic_stat_eoi", 3'd2, 32'h0);
        tick();
        chk("basic_req_after_eoi", {31'b0, irq_req}, 32'h0);

        // Ack outside REQ is ignored.
        ack();
        chk_reg("stray_ack_stat", 3'd2, 32'h0);

        // Priority: bits 4 and 2 together, 2 first.
        bus_write(3'd1, 32'h1C);
        pulse(32'h14);
        chk_reg("prio_pend", 3'd0, 32'h14);
        tick();
        chk("prio_vec2", {27'b0, irq_vec}, 32'd2);
        chk("prio_req2", {31'b0, irq_req}, 32'h1);
        ack();
        bus_write(3'd3, 32'h0);
        tick();
        chk("prio_vec4", {27'b0, irq_vec}, 32'd4);
        chk("prio_req4", {31'b0, irq_req}, 32'h1);
        pulse(32'h08);
        tick();
        chk("prio_vec_held", {27'b0, irq_vec}, 32'd4);
        chk_reg("prio_pend_18", 3'd0, 32'h18);
        ack();
        chk_reg("prio_stat_svc4", 3'd2, 32'h402);
        bus_write(3'd0, 32'hFFFF_FFFF);
        chk_reg("prio_w1c_all", 3'd0, 32'h0);
        bus_write(3'd3, 32'h0);

        // Withdrawal by disabling while in REQ.
        bus_write(3'd1, 32'h20);
        pulse(32'h20);
        tick();
        chk("wd_vec5", {27'b0, irq_vec}, 32'd5);
        chk("wd_req", {31'b0, irq_req}, 32'h1);
        bus_write(3'd1, 32'h0);
        tick();
        chk("wd_req_drop", {31'b0, irq_req}, 32'h0);
        chk_reg("wd_stat_idle", 3'd2, 32'h500);
        chk_reg("wd_pend5", 3'd0, 32'h20);
        bus_write(3'd1, 32'h20);
        tick();
        chk("wd_reappear_req", {31'b0, irq_req}, 32'h1);
        chk("wd_reappear_vec", {27'b0, irq_vec}, 32'd5);
        ack();
        irq_eoi = 1'b1;
        tick();
        irq_eoi = 1'b0;
        chk_reg("wd_eoi_pin", 3'd2, 32'h500);

        // Simultaneous W1C and rising edge on bit 1: the set wins.
        bus_write(3'd1, 32'h0);
        pulse(32'h2);
        tick();
        chk_reg("sim_pend_pre", 3'd0, 32'h2);
        irq_in = 32'h2;
        bus_write(3'd0, 32'h2);
        irq_in = '0;
        chk_reg("sim_set_wins", 3'd0, 32'h2);
        bus_write(3'd0, 32'h2);
        chk_reg("sim_w1c", 3'd0, 32'h0);

        // Software set.
        bus_write(3'd1, 32'h80);
        bus_write(3'd5, 32'h80);
        chk_reg("sw_pend", 3'd0, 32'h80);
        tick();
        chk("sw_req", {31'b0, irq_req}, 32'h1);
        chk("sw_vec", {27'b0, irq_vec}, 32'd7);
        ack();
        bus_write(3'd3, 32'h0);

        // Reset in the middle of servicing vector 0.
        bus_write(3'd1, 32'h7);
        pulse(32'h7);
        tick();
        chk("mid_vec0", {27'b0, irq_vec}, 32'd0);
        ack();
        chk_reg("mid_stat_svc", 3'd2, 32'h002);
        chk_reg("mid_pend6", 3'd0, 32'h6);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_reg("mid_rst_pend", 3'd0, 32'h0);
        chk_reg("mid_rst_ena",  3'd1, 32'h0);
        chk_reg("mid_rst_stat", 3'd2, 32'h0);
        chk("mid_rst_req", {31'b0, irq_req}, 32'h0);
        irq_eoi = 1'b1;
        tick();
        irq_eoi = 1'b0;
        tick();
        chk_reg("mid_eoi_ignored", 3'd2, 32'h0);
        chk("mid_req_final", {31'b0, irq_req}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/intc.md
Name: intc

Overview:
- Bus-mapped interrupt controller for the computer top.
- Collects peripheral IRQ lines (timer bit0, the rest reserved for uart, clock and others), latches rising edges as pending and masks them with an enable register.
- Schedules one request at a time to the CPU by fixed priority, with a req/ack/EOI handshake.
- Sits on the memory bus as an I/O slot (cs from the address decoder, dout into the bus_data_in mux).

Parameters:
- WIDTH, 32, bus data width.
- NIRQ, 32, number of IRQ inputs (1..32). Register bits at and above NIRQ read 0 and ignore writes.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- cs  input  1  chip select from address decoder
- wen  input  1  bus write enable
- addr  input  3  register select
- din  input  WIDTH  bus write data
- dout  output  WIDTH  bus read data
- irq_in  input  NIRQ  peripheral interrupt lines, level, synchronous to clk
- irq_req  output  1  request to CPU
- irq_vec  output  5  index of requested/in-service source
- irq_ack  input  1  CPU accepts request (1-cycle pulse)
- irq_eoi  input  1  CPU end-of-interrupt pulse (alternative to EOI register write)

Behaviour:
- Register map (word index = addr):
  - 0 PEND: R; W1C.
  - 1 ENA: RW.
  - 2 STAT: R; bit0 = req, bit1 = in-service, bits 12:8 = irq_vec.
  - 3 EOI: W; any write ends service.
  - 4 RAW: R; irq_in.
  - 5 SWSET: W1S into PEND.
  - 6, 7: read 0, writes ignored.
- Reads:
  - dout is combinational, valid in the same cycle as cs.
  - dout = 0 when cs = 0 or wen = 1.
- Writes: take effect on the clk edge where cs & wen.
- Edge detect:
  - prev register holds last irq_in.
  - rise = irq_in & ~prev.
  - PEND sets on rise regardless of ENA.
- PEND next-state order:
  - Start from PEND.
  - Clear W1C bits.
  - Clear the acked bit.
  - Then OR in rise | SWSET.
  - Result: a set in the same cycle as a clear wins (no edge lost).
- Priority:
  - candidate = lowest index i with PEND[i] & ENA[i].
  - any = OR of (PEND & ENA).
- FSM states:
  - IDLE: irq_req = 0. If any, latch irq_vec = candidate and go to REQ (irq_req rises 1 cycle after PEND&ENA becomes nonzero).
  - REQ: irq_req = 1 and irq_vec is held stable (a higher-priority arrival does not change it).
    - irq_ack: clear PEND[irq_vec], go to SVC.
    - Else if PEND[irq_vec] & ENA[irq_vec] falls to 0 (SW clear or disable): withdraw, go to IDLE, irq_req = 0 next cycle.
    - ack has priority over withdrawal in the same cycle.
  - SVC: irq_req = 0, in-service = 1, irq_vec held.
    - EOI write or irq_eoi pulse goes to IDLE.
    - New pending sources wait (no nesting).
  - irq_ack outside REQ, or EOI outside SVC, is ignored.
- Back-to-back: after EOI the FSM is in IDLE for one cycle, then re-arbitrates.
- Reset (synchronous, wins over every other event, including mid-handshake):
  - PEND = 0, ENA = 0, prev = 0, state = IDLE, irq_req = 0, irq_vec = 0.
  - A line held high through reset does not produce an edge after reset: prev samples irq_in from the first post-reset cycle on.

Test Plan:
- Reset, then read all registers:
  - PEND = 0, ENA = 0, STAT = 0, irq_req = 0.
  - With irq_in = 0x1 held during reset and after, PEND stays 0.
- Basic flow:
  - ENA = 0x1, then pulse irq_in[0].
  - PEND reads 0x1; irq_req = 1 one cycle later with irq_vec = 0.
  - ack: PEND = 0, STAT = 0x002.
  - Write EOI: STAT = 0, irq_req stays 0.
- Priority:
  - ENA = 0x1C, raise bits 4 and 2 in the same cycle: irq_vec = 2.
  - After ack + EOI: second request with irq_vec = 4.
  - Raising bit 3 while in REQ for vec 4 does not change irq_vec.
- Withdrawal:
  - In REQ for vec 5, write ENA = 0: irq_req drops next cycle, state IDLE, PEND[5] stays 1.
  - Re-enable: request reappears with vec 5.
- Simultaneous set and clear:
  - W1C PEND = 0x2 in the same cycle as a rise on irq_in[1]: PEND[1] = 1.
  - SWSET 0x80 with ENA = 0x80: request vec 7.
- Reset mid-operation:
  - In SVC for vec 0 with PEND = 0x6, assert reset for 1 cycle.
  - All registers 0, irq_req = 0; a later irq_eoi is ignored.
